// File: rtl/fifo_reader.sv
// Pops a commanded burst from a push/pop FIFO into a 2-entry (head + skid) valid/ready output buffer.
// Optional FIFO_READER_STALL_CNT_EN adds a saturating 16-bit backpressure cycle counter (io_stall_cycles).
module fifo_reader #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  fifo_dout,
  input  logic                   fifo_empty,
  output logic                   fifo_pop,
  input  logic                   io_start,
  input  logic [COUNT_WIDTH-1:0] io_count,
  input  logic                   io_abort,
  output logic [DATA_WIDTH-1:0]  io_out_data,
  output logic                   io_out_valid,
  input  logic                   io_out_ready,
  output logic                   io_busy,
`ifdef FIFO_READER_STALL_CNT_EN
  output logic [15:0]            io_stall_cycles,
`endif
  output logic                   io_done
);

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_t;

  state_t                 state_q;
  logic [COUNT_WIDTH-1:0] remaining_q;
  logic [1:0]             occ_q, occ_d;
  logic [DATA_WIDTH-1:0]  head_q, head_d, skid_q, skid_d;
  logic                   deq;

  assign io_out_valid = (occ_q != 2'd0);
  assign io_out_data  = head_q;
  assign io_busy      = (state_q != IDLE);
  assign io_done      = (state_q == DONE);
  assign deq          = io_out_valid & io_out_ready;

  // Gated by reset so a reset edge never consumes a FIFO word.
  assign fifo_pop = reset & (state_q == DRAIN) & !fifo_empty & (remaining_q != '0) & !io_abort
                    & ((occ_q < 2'd2) | io_out_ready);

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    skid_d = skid_q;
    case ({fifo_pop, deq})
      2'b10: begin
        if (occ_q == 2'd0) head_d = fifo_dout;
        else               skid_d = fifo_dout;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = skid_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_d = fifo_dout;
        end else begin
          head_d = skid_q;
          skid_d = fifo_dout;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      occ_q       <= 2'd0;
      head_q      <= '0;
      skid_q      <= '0;
`ifdef FIFO_READER_STALL_CNT_EN
      io_stall_cycles <= 16'd0;
`endif
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      skid_q <= skid_d;
      case (state_q)
        IDLE: begin
          if (io_start) begin
            if (io_count != '0) begin
              state_q     <= DRAIN;
              remaining_q <= io_count;
            end else begin
              state_q <= DONE;
            end
          end
        end
        DRAIN: begin
          if (io_abort) begin
            state_q <= FLUSH;
          end else if (fifo_pop) begin
            remaining_q <= remaining_q - COUNT_WIDTH'(1);
            if (remaining_q == COUNT_WIDTH'(1)) state_q <= FLUSH;
          end
        end
        FLUSH: begin
          if (occ_d == 2'd0) state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
`ifdef FIFO_READER_STALL_CNT_EN
      if (state_q == IDLE && io_start)
        io_stall_cycles <= 16'd0;
      else if (io_out_valid && !io_out_ready && io_stall_cycles != 16'hFFFF)
        io_stall_cycles <= io_stall_cycles + 16'd1;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: a queue-backed FIFO plus a transaction-level model of pops, buffered words and burst phase.
// Directed scenarios followed by randomized bursts with random ready, FIFO gaps, aborts and ignored starts.
module tb_fifo_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] fifo_dout;
  logic       fifo_empty;
  logic       fifo_pop;
  logic       io_start;
  logic [7:0] io_count;
  logic       io_abort;
  logic [7:0] io_out_data;
  logic       io_out_valid;
  logic       io_out_ready;
  logic       io_busy;
  logic       io_done;
`ifdef FIFO_READER_STALL_CNT_EN
  logic [15:0] io_stall_cycles;
`endif

  always #5 clk = ~clk;

  fifo_reader #(.DATA_WIDTH(8), .COUNT_WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .fifo_dout    (fifo_dout),
    .fifo_empty   (fifo_empty),
    .fifo_pop     (fifo_pop),
    .io_start     (io_start),
    .io_count     (io_count),
    .io_abort     (io_abort),
    .io_out_data  (io_out_data),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_busy      (io_busy),
`ifdef FIFO_READER_STALL_CNT_EN
    .io_stall_cycles (io_stall_cycles),
`endif
    .io_done      (io_done)
  );

  logic [7:0] fq[$];     // FIFO contents, head at index 0
  logic [7:0] exp_q[$];  // words popped but not yet accepted downstream
  bit  draining_m, flushing_m, done_m, hide;
  int  rem_m, stall_m;
  int  n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the rising edge.
  task automatic step();
    bit pop_m, pop_seen, acc, valid_m, idle_m, ends;
    logic [7:0] head;
    fifo_empty = (fq.size() == 0) | hide;
    fifo_dout  = (fq.size() != 0) ? fq[0] : 8'h00;
    #1;
    valid_m = (exp_q.size() != 0);
    idle_m  = !(draining_m | flushing_m | done_m);
    pop_m   = reset & draining_m & !fifo_empty & !io_abort & ((exp_q.size() < 2) | io_out_ready);
    check("busy", io_busy, !idle_m);
    check("done", io_done, done_m);
    check("pop", fifo_pop, pop_m);
    check("valid", io_out_valid, valid_m);
    if (valid_m) check("data", io_out_data, exp_q[0]);
`ifdef FIFO_READER_STALL_CNT_EN
    check("stall", io_stall_cycles, stall_m);
`endif
    pop_seen = fifo_pop;
    head     = fifo_dout;
    acc      = valid_m & io_out_ready;
    @(posedge clk);
    if (!reset) begin
      draining_m = 0; flushing_m = 0; done_m = 0; rem_m = 0; stall_m = 0;
      exp_q.delete();
    end else begin
      if (acc) void'(exp_q.pop_front());
      if (pop_seen && fq.size() != 0) begin
        void'(fq.pop_front());
        exp_q.push_back(head);
      end
      if (idle_m && io_start) stall_m = 0;
      else if (valid_m && !io_out_ready && stall_m < 65535) stall_m++;
      ends = 0;
      if (done_m) done_m = 0;
      if (flushing_m && exp_q.size() == 0) begin
        flushing_m = 0;
        done_m     = 1;
      end
      if (idle_m && io_start) begin
        if (io_count != 0) begin
          draining_m = 1;
          rem_m      = io_count;
        end else begin
          done_m = 1;
        end
      end else if (draining_m) begin
        if (io_abort) ends = 1;
        else if (pop_seen) begin
          rem_m--;
          if (rem_m == 0) ends = 1;
        end
      end
      if (ends) begin
        draining_m = 0;
        flushing_m = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while ((draining_m | flushing_m | done_m) && n < budget) begin
      step();
      n++;
    end
    #1 check("idle_budget", io_busy, 1'b0);
  endtask

  task automatic start_burst(input int cnt);
    io_start = 1; io_count = 8'(cnt);
    step();
    io_start = 0;
  endtask

  initial begin
    reset = 0; io_start = 0; io_count = 0; io_abort = 0; io_out_ready = 1; hide = 0;
    fifo_dout = 0; fifo_empty = 1;
    draining_m = 0; flushing_m = 0; done_m = 0; rem_m = 0; stall_m = 0;
    @(negedge clk);
    repeat (2) step();
    reset = 1;
    step();

    // Back-to-back burst of three with ready high
    fq = '{8'hA1, 8'hA2, 8'hA3};
    start_burst(3);
    run_until_idle(20);
    step();

    // Backpressure: two pops buffered, then stall until ready returns
    fq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    io_out_ready = 0;
    start_burst(5);
    repeat (6) step();
    io_out_ready = 1;
    run_until_idle(30);

    // Zero-length burst
    fq = '{8'h77};
    start_burst(0);
    run_until_idle(5);
    check("zero_len_fifo", fq.size(), 1);
    fq.delete();

    // FIFO runs dry mid-burst, then refills
    fq = '{8'hC1, 8'hC2};
    start_burst(4);
    repeat (6) step();
    fq.push_back(8'hC3); fq.push_back(8'hC4);
    run_until_idle(20);

    // Abort after two pops under backpressure
    fq = '{8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5, 8'hD6};
    io_out_ready = 0;
    start_burst(6);
    repeat (3) step();
    io_abort = 1; step(); io_abort = 0;
    repeat (2) step();
    io_out_ready = 1;
    run_until_idle(20);
    check("abort_fifo_left", fq.size(), 4);
    fq.delete();

    // Reset mid-drain with the buffer full
    fq = '{8'hE1, 8'hE2, 8'hE3, 8'hE4};
    io_out_ready = 0;
    start_burst(4);
    repeat (3) step();
    reset = 0; step(); reset = 1;
    step();
    check("reset_fifo_left", fq.size(), 2);
    fq.delete();
    io_out_ready = 1;
    fq = '{8'hF1, 8'hF2};
    start_burst(2);
    run_until_idle(20);

    // Seven backpressure cycles with a word waiting, then a new start
    fq = '{8'h5A, 8'h5B};
    io_out_ready = 0;
    start_burst(2);
    repeat (8) step();
    io_out_ready = 1;
    run_until_idle(20);
    fq = '{8'h6A};
    start_burst(1);
    run_until_idle(20);

    // Randomized bursts
    for (int b = 0; b < 40; b++) begin
      int cnt, extra, n;
      cnt   = $urandom_range(0, 7);
      extra = $urandom_range(0, 2);
      fq.delete();
      for (int k = 0; k < cnt + extra; k++) fq.push_back(8'($urandom));
      start_burst(cnt);
      n = 0;
      while ((draining_m | flushing_m | done_m) && n < 300) begin
        io_out_ready = ($urandom % 4) != 0;
        hide         = ($urandom % 5) == 0;
        io_abort     = ($urandom % 20) == 0;
        io_start     = (draining_m | flushing_m) && (($urandom % 8) == 0);
        io_count     = 8'($urandom_range(1, 9));
        step();
        n++;
      end
      io_start = 0; io_abort = 0; hide = 0; io_out_ready = 1;
      run_until_idle(20);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
